sat_expand: RTL



---
 rtl/sat_expand.sv | 125 ++++++++++++
 1 files changed

// File: rtl/sat_expand.sv
// sat_expand: receive-side widening stage for signed saturated samples.
//   Sign-extends isz-bit samples to osz bits and applies a left shift.
//   The shift is clamped to the available headroom (osz-isz).
//   Full-scale input codes (max positive / max negative) are flagged as
//   clip events and counted in a saturating counter for software monitoring.
//   Two-stage pipeline: valid follows ena by 2 clocks, with full throughput.
//
// Ports:
//   clk      - system clock, rising edge
//   reset    - asynchronous active-high reset
//   ena      - input sample valid strobe
//   in       - signed input sample [isz-1:0]
//   shift    - left-shift amount [shw-1:0], captured with each sample
//   clr      - synchronous clear of clip_cnt (and peak)
//   out      - signed widened, shifted sample [osz-1:0], holds between valids
//   valid    - single-cycle strobe per output sample
//   clip     - sample on out came from a full-scale input code
//   clip_cnt - saturating count of clip events [cw-1:0]
//   peak     - (only with SAT_EXPAND_PEAK_EN) unsigned peak |in| [isz-1:0]
//
// Optional feature macro: SAT_EXPAND_PEAK_EN
module sat_expand #(
  parameter int unsigned isz = 12,
  parameter int unsigned osz = 17,
  parameter int unsigned shw = 3,
  parameter int unsigned cw  = 16
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           ena,
  input  logic [isz-1:0] in,
  input  logic [shw-1:0] shift,
  input  logic           clr,
  output logic [osz-1:0] out,
  output logic           valid,
  output logic           clip,
`ifdef SAT_EXPAND_PEAK_EN
  output logic [isz-1:0] peak,
`endif
  output logic [cw-1:0]  clip_cnt
);

  localparam int unsigned hr = osz - isz;

  localparam logic [isz-1:0] max_pos = {1'b0, {(isz-1){1'b1}}};
  localparam logic [isz-1:0] max_neg = {1'b1, {(isz-1){1'b0}}};

  // stage 1
  logic [isz-1:0] in1;
  logic [shw-1:0] sh1;
  logic           fs1;
  logic           v1;

  // stage 2 combinational helpers
  logic [osz-1:0] ext;
  logic [31:0]    s_eff;
  logic           event_clip;

  always_comb begin
    ext        = {{hr{in1[isz-1]}}, in1};
    s_eff      = (32'(sh1) > hr) ? hr : 32'(sh1);
    event_clip = fs1 & v1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      in1 <= '0;
      sh1 <= '0;
      fs1 <= 1'b0;
      v1  <= 1'b0;
    end else begin
      v1 <= ena;
      if (ena) begin
        in1 <= in;
        sh1 <= shift;
        fs1 <= (in == max_pos) || (in == max_neg);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out   <= '0;
      valid <= 1'b0;
      clip  <= 1'b0;
    end else begin
      valid <= v1;
      if (v1) begin
        out  <= ext << s_eff;
        clip <= fs1;
      end
    end
  end

  // clr wins over the old count but a same-cycle event still counts as one
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      clip_cnt <= '0;
    end else if (clr) begin
      clip_cnt <= event_clip ? cw'(1) : '0;
    end else if (event_clip && (clip_cnt != '1)) begin
      clip_cnt <= clip_cnt + cw'(1);
    end
  end

`ifdef SAT_EXPAND_PEAK_EN
  // |max neg| = 2^(isz-1) still fits as an unsigned isz-bit value
  logic [isz-1:0] mag1;

  always_comb begin
    mag1 = in1[isz-1] ? (~in1 + isz'(1)) : in1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      peak <= '0;
    end else if (clr) begin
      peak <= v1 ? mag1 : '0;
    end else if (v1 && (mag1 > peak)) begin
      peak <= mag1;
    end
  end
`endif

endmodule
